// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared defaults and FSM state encoding for the divider scheduler
// Contents:
//   DIV_DATAWIDTH  default operand/result width
//   DIV_NREQ       default number of requesters
//   div_state_t    scheduler FSM states (IDLE, CALC, DONE)
package div_pkg;

    localparam int DIV_DATAWIDTH = 24;
    localparam int DIV_NREQ      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_iter_core.sv
// rtl/div_iter_core.sv - unsigned restoring divider, one quotient bit per cycle, MSB first
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        load operands and begin a W-iteration division
//   dividend     dividend, sampled on start
//   divisor      divisor, sampled on start
//   done         high during the final iteration cycle
//   quotient     result of the current iteration (final value when done)
//   remainder    result of the current iteration (final value when done)
// A zero divisor naturally yields an all-ones quotient and remainder = dividend.
module div_iter_core #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]  dvd_sh;
    logic [W-1:0]  dvs;
    logic [W-1:0]  rem;
    logic [W-1:0]  quo;
    logic [CW-1:0] cnt;
    logic          active;

    logic [W:0]    trial;
    logic          ge;
    logic [W:0]    rem_next;

    // One restoring step evaluated combinationally; done/quotient/remainder
    // expose the step's result so the caller can latch it on the last edge.
    always_comb begin
        trial    = {rem, dvd_sh[W-1]};
        ge       = (trial >= {1'b0, dvs});
        rem_next = ge ? (trial - {1'b0, dvs}) : trial;
    end

    assign done      = active && (cnt == CW'(W - 1));
    assign quotient  = {quo[W-2:0], ge};
    assign remainder = rem_next[W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_sh <= '0;
            dvs    <= '0;
            rem    <= '0;
            quo    <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            dvd_sh <= dividend;
            dvs    <= divisor;
            rem    <= '0;
            quo    <= '0;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            dvd_sh <= {dvd_sh[W-2:0], 1'b0};
            rem    <= rem_next[W-1:0];
            quo    <= quotient;
            cnt    <= cnt + CW'(1);
            if (cnt == CW'(W - 1)) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/div_scheduler.sv
// rtl/div_scheduler.sv - round-robin arbiter sharing one iterative divider among NREQ requesters
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid / req_ready          per-requester handshake (ready one-hot, IDLE only)
//   req_dividend / req_divisor     packed operands, requester i at slice i
//   rsp_valid / rsp_ready          result handshake
//   rsp_id                         requester owning the result
//   rsp_quotient / rsp_remainder   unsigned result
//   rsp_div0                       divisor was zero
//   busy                           FSM not in IDLE
module div_scheduler
    import div_pkg::*;
#(
    parameter int DATAWIDTH = DIV_DATAWIDTH,
    parameter int NREQ      = DIV_NREQ
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*DATAWIDTH-1:0] req_dividend,
    input  logic [NREQ*DATAWIDTH-1:0] req_divisor,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [DATAWIDTH-1:0]      rsp_quotient,
    output logic [DATAWIDTH-1:0]      rsp_remainder,
    output logic                      rsp_div0,
    output logic                      busy
);

    localparam int IDW = $clog2(NREQ);

    div_state_t           state;
    logic [IDW-1:0]       rr_ptr;
    logic [IDW-1:0]       id_q;
    logic                 div0_q;

    logic                 grant_found;
    logic [IDW-1:0]       grant_idx;
    logic                 handshake;
    logic [DATAWIDTH-1:0] sel_dividend;
    logic [DATAWIDTH-1:0] sel_divisor;

    logic                 core_done;
    logic [DATAWIDTH-1:0] core_quotient;
    logic [DATAWIDTH-1:0] core_remainder;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin : arb
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(idx);
            end
        end
    end

    assign handshake = (state == ST_IDLE) && grant_found;

    // Gated by rst_n so ready drops the moment reset asserts.
    assign req_ready = (handshake && rst_n) ? (NREQ'(1) << grant_idx) : '0;

    assign sel_dividend = req_dividend[int'(grant_idx)*DATAWIDTH +: DATAWIDTH];
    assign sel_divisor  = req_divisor[int'(grant_idx)*DATAWIDTH +: DATAWIDTH];

    assign busy = (state != ST_IDLE);

    div_iter_core #(
        .W (DATAWIDTH)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (handshake),
        .dividend  (sel_dividend),
        .divisor   (sel_divisor),
        .done      (core_done),
        .quotient  (core_quotient),
        .remainder (core_remainder)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            id_q          <= '0;
            div0_q        <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_div0      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        id_q   <= grant_idx;
                        div0_q <= (sel_divisor == '0);
                        rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
                        state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (core_done) begin
                        rsp_valid     <= 1'b1;
                        rsp_id        <= id_q;
                        rsp_quotient  <= div0_q ? '1 : core_quotient;
                        rsp_remainder <= core_remainder;
                        rsp_div0      <= div0_q;
                        state         <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid     <= 1'b0;
                        rsp_id        <= '0;
                        rsp_quotient  <= '0;
                        rsp_remainder <= '0;
                        rsp_div0      <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_scheduler.sv
// tb/tb_div_scheduler.sv - randomized self-checking bench for div_scheduler
module tb_div_scheduler;

    localparam int W = 24;
    localparam int N = 4;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_dividend;
    logic [N*W-1:0]   req_divisor;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [W-1:0]     rsp_quotient;
    logic [W-1:0]     rsp_remainder;
    logic             rsp_div0;
    logic             busy;

    logic [W-1:0]     dvd [N];
    logic [W-1:0]     dvs [N];

    int n_tests = 0;
    int n_fail  = 0;
    int mrr     = 0;

    div_scheduler #(
        .DATAWIDTH (W),
        .NREQ      (N)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_div0      (rsp_div0),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_dividend = '0;
        req_divisor  = '0;
        for (int i = 0; i < N; i++) begin
            req_dividend[i*W +: W] = dvd[i];
            req_divisor[i*W +: W]  = dvs[i];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int model_grant(input logic [N-1:0] m);
        for (int k = 0; k < N; k++) begin
            if (m[(mrr + k) % N]) return (mrr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] rand_divisor();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return W'($urandom_range(1, 15));
            default: return W'($urandom);
        endcase
    endfunction

    function automatic logic [56:0] out_vec();
        return {req_ready, rsp_valid, rsp_id, rsp_div0, busy, rsp_quotient, rsp_remainder};
    endfunction

    task automatic apply_reset(input string tag);
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        #1;
        check({tag, "_rst_outputs"}, 64'(out_vec()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mrr   = 0;
    endtask

    // One complete operation: grant, fixed latency, result, optional back-pressure, release.
    task automatic run_op(input logic [N-1:0] vmask, input logic [N-1:0] after_mask,
                          input int hold, input string tag);
        int           eg;
        int           lat;
        logic         bad;
        logic [W-1:0] ea, eb, eq, er;
        logic         ediv0;
        req_valid = vmask;
        #1;
        eg = model_grant(vmask);
        check({tag, "_grant"}, 64'(req_ready), 64'(1) << eg);
        ea = dvd[eg];
        eb = dvs[eg];
        if (eb == '0) begin
            eq = '1; er = ea; ediv0 = 1'b1;
        end else begin
            eq = ea / eb; er = ea % eb; ediv0 = 1'b0;
        end
        @(posedge clk);
        #1;
        mrr       = (eg + 1) % N;
        req_valid = after_mask;
        for (int i = 0; i < N; i++) begin
            dvd[i] = W'($urandom);
            dvs[i] = W'($urandom);
        end
        lat = 0;
        bad = 1'b0;
        while (!rsp_valid && lat < 100) begin
            if (busy !== 1'b1 || req_ready !== '0) bad = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(W));
        check({tag, "_calc_state"}, 64'(bad), 64'd0);
        check({tag, "_result"}, {7'd0, rsp_id, rsp_div0, rsp_quotient, rsp_remainder},
              {7'd0, 2'(eg), ediv0, eq, er});
        bad = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b1 || busy !== 1'b1 || req_ready !== '0 ||
                rsp_id !== 2'(eg) || rsp_quotient !== eq || rsp_remainder !== er ||
                rsp_div0 !== ediv0) bad = 1'b1;
        end
        if (hold > 0) check({tag, "_hold_stable"}, 64'(bad), 64'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, "_back_idle"}, {62'd0, rsp_valid, busy}, 64'd0);
    endtask

    initial begin
        logic         seen;
        logic [N-1:0] m;
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            dvd[i] = '0;
            dvs[i] = '0;
        end
        apply_reset("init");

        // Basic results and divide-by-zero
        dvd[0] = 24'd100;  dvs[0] = 24'd7;
        run_op(4'b0001, 4'b0000, 0, "r0_100_7");
        dvd[2] = 24'd1234; dvs[2] = 24'd0;
        run_op(4'b0100, 4'b0000, 0, "r2_div0");

        // Round-robin with everyone requesting from reset
        req_valid = 4'b1111;
        apply_reset("rr");
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < N; i++) begin
                dvd[i] = W'($urandom);
                dvs[i] = rand_divisor();
            end
            run_op(4'b1111, 4'b1111, 0, $sformatf("rr_all%0d", k));
        end
        run_op(4'b1010, 4'b1010, 0, "rr_odd_a");
        run_op(4'b1010, 4'b0000, 0, "rr_odd_b");

        // Back-pressure for 10 cycles with requests pending
        dvd[0] = 24'd999999; dvs[0] = 24'd123;
        run_op(4'b0001, 4'b1111, 10, "hold10");
        req_valid = '0;
        #1;

        // Reset in the 10th CALC cycle aborts the operation
        dvd[1] = 24'd5000; dvs[1] = 24'd3;
        req_valid = 4'b0010;
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (9) @(posedge clk);
        #1;
        check("abort_in_calc", 64'(busy), 64'd1);
        apply_reset("abort");
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        check("abort_no_rsp", 64'(seen), 64'd0);
        dvd[3] = 24'd77777; dvs[3] = 24'd11;
        run_op(4'b1000, 4'b0000, 0, "after_abort_r3");

        // Boundaries
        dvd[1] = 24'hFFFFFF; dvs[1] = 24'd1;
        run_op(4'b0010, 4'b0000, 0, "max_div1");
        dvd[2] = 24'd5; dvs[2] = 24'd9;
        run_op(4'b0100, 4'b0000, 0, "small_over_big");

        // Randomized traffic
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < N; i++) begin
                dvd[i] = W'($urandom);
                dvs[i] = rand_divisor();
            end
            m = N'($urandom_range(1, 15));
            run_op(m, ($urandom_range(0, 1) == 1) ? m : 4'b0000, $urandom_range(0, 3),
                   $sformatf("rand%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
